// File: rtl/k12a_lcd_monitor.sv
// Passive HD44780 bus decoder: DDRAM shadow, cursor and display state; one-cycle event after each strobe.
// K12A_LCD_4BIT_EN adds 4-bit nibble assembly; without it the bus is always 8-bit.
module k12a_lcd_monitor #(
   parameter int          LINE_LEN = 16,
   parameter logic [7:0]  BLANK    = 8'h20,
   localparam int         DEPTH    = 2 * LINE_LEN,
   localparam int         AW       = $clog2(DEPTH)
) (
   input  logic          cpu_clock,
   input  logic          reset_n,
   input  logic          lcd_rs,
   input  logic          lcd_rw,
   input  logic          lcd_en,
   input  logic [7:0]    lcd_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic [AW-1:0] cursor,
   output logic          display_on,
   output logic          busy,
   output logic          busy_violation,
   output logic          event_valid,
   output logic          event_is_data,
   output logic [7:0]    event_byte,
   output logic [15:0]   wr_count
);
   localparam int LW = $clog2(LINE_LEN);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t        r_state, w_state_nxt;
   logic          r_en_q, r_rs_q, r_rw_q;
   logic [7:0]    r_data_q;
   logic          r_stb, r_stb_rs;
   logic [7:0]    r_stb_dat;
   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_cursor, r_sweep;
   logic          r_dir, r_disp, r_viol, r_ev_vld, r_ev_rs;
   logic [7:0]    r_ev_byte;
   logic [15:0]   r_wr_cnt;
   logic          w_strobe, w_idle_stb, w_acc, w_cmd_clr;
   logic [7:0]    w_byte;

   assign w_strobe   = r_en_q & ~lcd_en;
   assign w_idle_stb = r_stb & (r_state == S_IDLE);

   // Pin sampling plus one strobe stage: strobe seen at edge N is acted on at edge N+1.
   always_ff @(posedge cpu_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_en_q    <= 1'b0;
         r_rs_q    <= 1'b0;
         r_rw_q    <= 1'b0;
         r_data_q  <= 8'h00;
         r_stb     <= 1'b0;
         r_stb_rs  <= 1'b0;
         r_stb_dat <= 8'h00;
      end else begin
         r_en_q    <= lcd_en;
         r_rs_q    <= lcd_rs;
         r_rw_q    <= lcd_rw;
         r_data_q  <= lcd_data;
         r_stb     <= w_strobe & ~r_rw_q;
         r_stb_rs  <= r_rs_q;
         r_stb_dat <= r_data_q;
      end
   end

`ifdef K12A_LCD_4BIT_EN
   logic       r_mode4, r_nib_ph;
   logic [3:0] r_nib_hi;

   always_comb begin
      w_byte = r_stb_dat;
      w_acc  = w_idle_stb;
      if (r_mode4) begin
         w_byte = {r_nib_hi, r_stb_dat[7:4]};
         w_acc  = w_idle_stb & r_nib_ph;
      end
   end

   always_ff @(posedge cpu_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_mode4  <= 1'b0;
         r_nib_ph <= 1'b0;
         r_nib_hi <= 4'h0;
      end else if (r_stb && r_state == S_CLEAR) begin
         r_nib_ph <= 1'b0;
      end else if (w_idle_stb && r_mode4 && !r_nib_ph) begin
         r_nib_hi <= r_stb_dat[7:4];
         r_nib_ph <= 1'b1;
      end else if (w_acc) begin
         r_nib_ph <= 1'b0;
         if (!r_stb_rs && w_byte[7:5] == 3'b001)
            r_mode4 <= ~w_byte[4];
      end
   end
`else
   assign w_byte = r_stb_dat;
   assign w_acc  = w_idle_stb;
`endif

   assign w_cmd_clr = w_acc & ~r_stb_rs & (w_byte == 8'h01);

   always_ff @(posedge cpu_clock or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_cmd_clr) w_state_nxt = S_CLEAR;
         S_CLEAR: if (r_sweep == AW'(DEPTH - 1)) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge cpu_clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= BLANK;
         r_cursor  <= '0;
         r_sweep   <= '0;
         r_dir     <= 1'b1;
         r_disp    <= 1'b0;
         r_viol    <= 1'b0;
         r_ev_vld  <= 1'b0;
         r_ev_rs   <= 1'b0;
         r_ev_byte <= 8'h00;
         r_wr_cnt  <= 16'h0000;
      end else begin
         r_ev_vld <= w_acc;
         if (w_acc) begin
            r_ev_rs   <= r_stb_rs;
            r_ev_byte <= w_byte;
         end
         if (r_state == S_CLEAR) begin
            r_mem[r_sweep] <= BLANK;
            r_sweep        <= r_sweep + 1'b1;
            if (r_stb) r_viol <= 1'b1;
         end
         if (w_acc) begin
            if (r_stb_rs) begin
               r_mem[r_cursor] <= w_byte;
               r_wr_cnt        <= r_wr_cnt + 16'd1;
               r_cursor        <= r_dir ? r_cursor + 1'b1 : r_cursor - 1'b1;
            end else begin
               // Commands decode on their highest set bit.
               casez (w_byte)
                  8'b1???????: r_cursor <= {w_byte[6], w_byte[LW-1:0]};
                  8'b00001???: r_disp   <= w_byte[2];
                  8'b000001??: r_dir    <= w_byte[1];
                  8'b0000001?: r_cursor <= '0;
                  8'b00000001: begin
                     r_cursor <= '0;
                     r_dir    <= 1'b1;
                     r_sweep  <= '0;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign rd_data        = r_mem[rd_addr];
   assign cursor         = r_cursor;
   assign display_on     = r_disp;
   assign busy           = (r_state == S_CLEAR);
   assign busy_violation = r_viol;
   assign event_valid    = r_ev_vld;
   assign event_is_data  = r_ev_rs;
   assign event_byte     = r_ev_byte;
   assign wr_count       = r_wr_cnt;
endmodule
